// File: rtl/dmem_arbiter.sv
// Two-port valid/ready arbiter and sequencer for the single-ported data_memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.

package dmem_pkg;
  typedef logic [31:0] word;

  typedef enum logic {
    MEM_READ_EN  = 1'b0,
    MEM_WRITE_EN = 1'b1
  } mem_en_t;

  typedef struct packed {
    logic    mem_enable;
    mem_en_t mem_en;
    word     address;
    word     data_in;
  } data_memory_interface_t;
endpackage

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_write,
  input  word  [1:0]             req_addr,
  input  word  [1:0]             req_wdata,
  output logic [1:0]             req_ready,
  output logic [1:0]             resp_valid,
  output logic                   resp_err,
  output word                    resp_rdata,
  output data_memory_interface_t mem_sig,
  input  word                    mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam word LIMIT = word'(ADDR_LIMIT);

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic       write_q, write_d;
  word        addr_q, addr_d;
  word        wdata_q, wdata_d;
  word        rdata_q, rdata_d;
  logic       err_q, err_d;
  logic       win;
  logic [1:0] ready;
  logic       in_range;

  assign in_range = addr_q < LIMIT;

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;

  // On contention the port not granted last wins; a lone requester always wins.
  always_comb begin
    if (req_valid == 2'b11) win = ~last_q;
    else                    win = req_valid[1] & ~req_valid[0];
  end

  assign last_d = (state_q == IDLE && req_valid != 2'b00) ? win : last_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`else
  assign win = ~req_valid[0];
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ready      = '0;
    resp_valid = '0;
    mem_sig    = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          ready[win] = 1'b1;
          grant_d    = win;
          write_d    = req_write[win];
          addr_d     = req_addr[win];
          wdata_d    = req_wdata[win];
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (in_range) begin
          mem_sig.mem_enable = 1'b1;
          mem_sig.mem_en     = write_q ? MEM_WRITE_EN : MEM_READ_EN;
          mem_sig.address    = addr_q;
          mem_sig.data_in    = wdata_q;
          rdata_d            = write_q ? '0 : mem_rdata;
          err_d              = 1'b0;
        end else begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid[grant_q] = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State is IDLE while reset is held, so the accept strobe is masked explicitly.
  assign req_ready  = ready & {2{reset_n}};
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: driver pushes expected responses at accept, monitor pops on response.
`timescale 1ns/1ps

module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int unsigned ADDR_LIMIT = 1024;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic write;
    word  addr;
    word  wdata;
  } req_t;

  typedef struct {
    logic        port;
    logic        write;
    logic        err;
    word         addr;
    word         wdata;
    word         rdata;
    int unsigned acc;
  } exp_t;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  logic [1:0]             req_valid = '0;
  logic [1:0]             req_write = '0;
  word  [1:0]             req_addr = '0;
  word  [1:0]             req_wdata = '0;
  logic [1:0]             req_ready;
  logic [1:0]             resp_valid;
  logic                   resp_err;
  word                    resp_rdata;
  data_memory_interface_t mem_sig;
  word                    mem_rdata;

  dmem_arbiter #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_sig    (mem_sig),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // Environment: the data_memory itself.
  word dmem [256];
  assign mem_rdata = dmem[mem_sig.address[9:2]];
  always @(posedge clock)
    if (mem_sig.mem_enable && mem_sig.mem_en == MEM_WRITE_EN)
      dmem[mem_sig.address[9:2]] <= mem_sig.data_in;

  // Reference model state.
  word         ref_mem [256];
  word         snap [256];
  exp_t        sbq [$];
  req_t        src0 [$];
  req_t        src1 [$];
  int unsigned cyc = 0;
  int unsigned next_ok = 0;
  logic        last_g = 1'b1;
  logic [1:0]  took = '0;
  int unsigned load_pct = 100;
  int unsigned compared = 0;
  int unsigned mismatched = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(string name, logic [95:0] act, logic [95:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic req_t mk(logic w, word a, word d);
    req_t r;
    r.write = w;
    r.addr  = a;
    r.wdata = d;
    return r;
  endfunction

  task automatic check_reset_outputs();
    check("rst_req_ready",  96'(req_ready),  96'(0));
    check("rst_resp_valid", 96'(resp_valid), 96'(0));
    check("rst_resp_err",   96'(resp_err),   96'(0));
    check("rst_resp_rdata", 96'(resp_rdata), 96'(0));
    check("rst_mem_sig",    96'(mem_sig),    96'(0));
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    took      = '0;
    #1;
    check_reset_outputs();
    sbq.delete();
    next_ok = 0;
    last_g  = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  // Called at a falling edge: decide from the rules who must be accepted now.
  task automatic check_accept();
    logic [1:0] exp_rdy;
    logic       w;
    exp_t       e;
    exp_rdy = '0;
    w       = 1'b0;
    if (cyc >= next_ok && req_valid != 2'b00) begin
      if (req_valid == 2'b11) w = RR ? ~last_g : 1'b0;
      else                    w = req_valid[1];
      exp_rdy[w] = 1'b1;
    end
    check("req_ready", 96'(req_ready), 96'(exp_rdy));
    if (exp_rdy != 2'b00) begin
      e.port  = w;
      e.write = req_write[w];
      e.addr  = req_addr[w];
      e.wdata = req_wdata[w];
      e.acc   = cyc;
      e.err   = (e.addr >= ADDR_LIMIT);
      e.rdata = (e.err || e.write) ? '0 : ref_mem[e.addr[9:2]];
      if (!e.err && e.write) ref_mem[e.addr[9:2]] = e.wdata;
      sbq.push_back(e);
      last_g  = w;
      next_ok = cyc + 3;
      took[w] = 1'b1;
    end
  endtask

  task automatic load_ports();
    req_t r;
    logic has;
    for (int p = 0; p < 2; p++) begin
      logic pi;
      pi = 1'(p);
      if (took[pi] || !req_valid[pi]) begin
        req_valid[pi] = 1'b0;
        req_write[pi] = 1'($urandom_range(0, 1));
        req_addr[pi]  = $urandom;
        req_wdata[pi] = $urandom;
        has = pi ? (src1.size() != 0) : (src0.size() != 0);
        if (has && $urandom_range(0, 99) < load_pct) begin
          r = pi ? src1.pop_front() : src0.pop_front();
          req_valid[pi] = 1'b1;
          req_write[pi] = r.write;
          req_addr[pi]  = r.addr;
          req_wdata[pi] = r.wdata;
        end
      end
      took[pi] = 1'b0;
    end
  endtask

  task automatic cycle_drive();
    @(negedge clock);
    check_accept();
    @(posedge clock);
    #1;
    load_ports();
  endtask

  task automatic run(int unsigned budget);
    int unsigned n;
    n = 0;
    while ((src0.size() != 0 || src1.size() != 0 || req_valid != 2'b00 || sbq.size() != 0)
           && n < budget) begin
      cycle_drive();
      n++;
    end
    if (n >= budget) begin
      compared++;
      mismatched++;
      $display("FAIL run_timeout: got %0d cycles expected under %0d", n, budget);
    end
  endtask

  // Monitor: memory bundle every cycle, response pulses popped from the scoreboard.
  exp_t                   me;
  data_memory_interface_t exp_m;
  logic [1:0]             exp_v;
  always @(negedge clock) begin
    if (reset_n) begin
      exp_m = '0;
      exp_v = '0;
      if (sbq.size() != 0 && cyc == sbq[0].acc + 1 && !sbq[0].err) begin
        exp_m.mem_enable = 1'b1;
        exp_m.mem_en     = sbq[0].write ? MEM_WRITE_EN : MEM_READ_EN;
        exp_m.address    = sbq[0].addr;
        exp_m.data_in    = sbq[0].wdata;
      end
      check("mem_sig", 96'(mem_sig), 96'(exp_m));
      if (resp_valid != 2'b00 || (sbq.size() != 0 && cyc >= sbq[0].acc + 2)) begin
        if (sbq.size() == 0) begin
          check("resp_unexpected", 96'(resp_valid), 96'(0));
        end else begin
          me = sbq.pop_front();
          exp_v[me.port] = 1'b1;
          check("resp_valid",  96'(resp_valid), 96'(exp_v));
          check("resp_cycle",  96'(cyc),        96'(me.acc + 2));
          check("resp_err",    96'(resp_err),   96'(me.err));
          check("resp_rdata",  96'(resp_rdata), 96'(me.rdata));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    req_t r;
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = '0;
      ref_mem[i] = '0;
    end
    #3;
    do_reset();

    // Reset during the ACCESS cycle of a write drops it.
    src0.push_back(mk(1'b1, 32'h10, 32'h1111_1111));
    src0.push_back(mk(1'b0, 32'h10, 32'h0));
    run(60);
    snap = ref_mem;
    src0.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF));
    for (int k = 0; k < 20 && sbq.size() == 0; k++) cycle_drive();
    if (sbq.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL abort_accept: got no accept expected one");
    end
    @(negedge clock);
    #2;
    do_reset();
    ref_mem = snap;
    src0.push_back(mk(1'b0, 32'h10, $urandom));
    run(60);

    // Port 0 write/read and low address bits.
    src0.push_back(mk(1'b1, 32'h40, 32'h1234_5678));
    src0.push_back(mk(1'b0, 32'h40, $urandom));
    src0.push_back(mk(1'b1, 32'h43, 32'hA5A5_A5A5));
    src0.push_back(mk(1'b0, 32'h40, $urandom));
    run(80);

    // Range boundary on port 1.
    src1.push_back(mk(1'b0, 32'h400, $urandom));
    src1.push_back(mk(1'b1, 32'h400, 32'hCAFE_F00D));
    src1.push_back(mk(1'b0, 32'h3FF, $urandom));
    src1.push_back(mk(1'b1, 32'hFFFF_FFFC, 32'h0BAD_0BAD));
    src1.push_back(mk(1'b0, 32'h0, $urandom));
    run(80);

    // Continuous contention from reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src0.push_back(mk(1'b0, word'(i * 4), $urandom));
      src1.push_back(mk(1'b0, word'(32'h40 + i * 4), $urandom));
    end
    run(100);

    // Randomized mixed traffic.
    load_pct = 70;
    for (int i = 0; i < 60; i++) begin
      r.write = 1'($urandom_range(0, 1));
      r.wdata = $urandom;
      case ($urandom_range(0, 7))
        0:       r.addr = word'(ADDR_LIMIT + $urandom_range(0, 4096));
        1:       r.addr = word'($urandom_range(1020, 1027));
        default: r.addr = word'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 1) == 0) src0.push_back(r);
      else                           src1.push_back(r);
    end
    run(2000);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-ported `data_memory` (256 × `word`, combinational read, write on `posedge clock`). Port 0 is the core load/store unit. Port 1 is the debug/program-loader port. The block accepts one request at a time over a valid/ready handshake and drives `data_memory_interface_t` for exactly one cycle per transaction. It registers read data and returns a one-cycle response pulse to the granted requester.

## Interface
Parameters:
- `ADDR_LIMIT`, default 1024: byte-address bound. Addresses ≥ `ADDR_LIMIT` are rejected without touching memory.

Ports:
- `clock`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  [1:0]  per-port request valid
- `req_write`  in  [1:0]  per-port direction: 1 = write, 0 = read
- `req_addr`  in  2 × `word`  per-port byte address
- `req_wdata`  in  2 × `word`  per-port write data
- `req_ready`  out  [1:0]  per-port accept strobe
- `resp_valid`  out  [1:0]  per-port completion pulse
- `resp_err`  out  1  completion was an out-of-range reject; valid with `resp_valid`
- `resp_rdata`  out  `word`  read data; valid with `resp_valid`
- `mem_sig`  out  `data_memory_interface_t`  memory control bundle
- `mem_rdata`  in  `word`  memory `data_out`

## Operation
- FSM states: `IDLE`, `ACCESS`, `RESP`. Reset state is `IDLE`.
- **IDLE**
  - If any `req_valid` is high, the arbiter picks winner `g`.
  - `req_ready[g]` = 1 combinationally in this state only.
  - At the edge, it latches `g`, write, address and wdata.
  - Next state: `ACCESS`.
- **ACCESS**, in range (latched addr < `ADDR_LIMIT`)
  - Drive `mem_sig.mem_enable` = 1.
  - Drive `mem_sig.mem_en` = `MEM_WRITE_EN` or `MEM_READ_EN`.
  - Drive `mem_sig.address` = latched address and `mem_sig.data_in` = latched wdata.
  - Reads: capture `mem_rdata` into the rdata register at the closing edge.
  - Writes: memory commits at that same edge; the rdata register is loaded with 0.
- **ACCESS**, out of range
  - `mem_enable` stays 0.
  - Set the error flag; rdata register = 0.
- Next state after `ACCESS`: `RESP`.
- **RESP**
  - `resp_valid[g]` = 1; `resp_rdata` and `resp_err` come from registers.
  - Next state: `IDLE`.
- Outside `ACCESS`, `mem_sig` is all-zero (`mem_enable` = 0).
- Address bits [1:0] pass through unmodified. Memory ignores them; no alignment fault is raised.
- A requester must hold `req_*` stable from asserting `req_valid` until it sees `req_ready`. After acceptance it may change or drop them.
- Requests that arrive during `ACCESS`/`RESP` wait and are considered at the next `IDLE` cycle.

## Timing
- Reset (`reset_n` low, asynchronous): state `IDLE`.
  - `req_ready` = 0, `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0, `mem_sig` = 0.
  - Round-robin pointer = port 1, so port 0 wins first.
- Accept edge T0 → `ACCESS` during T0–T1 → `resp_valid` during T1–T2 → `IDLE` at T2.
- Read latency: 2 cycles from the accept edge to the response cycle.
- Throughput: one transaction per 3 cycles when requests are continuous.
- Reset mid-transaction:
  - `mem_sig.mem_enable` drops immediately, so an uncommitted write is lost.
  - No `resp_valid` is produced; the requester must reissue.
- Simultaneous `req_valid` = 2'b11 is resolved by the policy in Configuration; only one `req_ready` bit is ever set.
- `req_ready` and `resp_valid` are each at most one-hot. They are never high in the same cycle.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - On contention, the grant goes to the port not granted last.
  - The pointer updates on every accept.
- `DMEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins.
  - The pointer register is not implemented.
  - Port 1 may starve under continuous port-0 traffic, which is accepted behaviour.

## Test plan
- **Reset values:** hold `reset_n` low mid-`ACCESS` of a write (addr 0x10, data 0xDEADBEEF).
  - All outputs 0 immediately.
  - A later read of 0x10 returns its prior value.
- **Write then read, port 0:** write 0x0000_0040 ← 0x1234_5678, then read 0x40.
  - `req_ready[0]` in the IDLE cycle.
  - `mem_enable` exactly one cycle per transaction.
  - `resp_valid[0]` two cycles after each accept edge.
  - Read returns 0x1234_5678 with `resp_err` = 0.
- **Contention:** both ports request reads every cycle from reset.
  - With RR: grants alternate 0,1,0,1.
  - Without RR: grants are 0,0,0,… and `req_ready[1]` is never set.
- **Out of range:** port 1 reads 0x400 (with `ADDR_LIMIT` = 1024).
  - `mem_enable` stays 0.
  - `resp_valid[1]` with `resp_err` = 1 and `resp_rdata` = 0.
- **Back-to-back spacing:** port 0 holds `req_valid` for 4 reads.
  - Accept edges are exactly 3 cycles apart.
  - `req_ready` and `resp_valid` never overlap.
- **Address low bits:** write 0x43 ← 0xA5A5A5A5, then read 0x40.
  - `mem_sig.address` = 0x43 during the write's `ACCESS`.
  - Read returns 0xA5A5A5A5.
